spi_flash_ctrl: RTL and testbench

Read-only Wishbone slave that maps an external SPI NOR flash into the system address space. Each Wishbone read is turned into one standard SPI READ (0x03) transaction that fetches one 32-bit word. After reset the block first wakes the flash with a Release-Power-Down (0xAB) command. It sits between the SoC Wishbone interconnect and the flash pins (CS#, SCK, MOSI, MISO); WP# and HOLD#/RESET# are driven at board/top level.

---
 rtl/spi_flash_ctrl.sv | 94 +++++++++
 tb/tb_spi_flash_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: read-only Wishbone window onto SPI NOR flash, one 0x03 READ per 32-bit word, 0xAB wake after reset
module spi_flash_ctrl #(
  parameter int WAKE_DELAY = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        o_spi_cs_n,
  output logic        o_spi_clk,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);
  typedef enum logic [2:0] {WAKE, WAKE_WAIT, IDLE, XFER, ACK, GAP} state_t;
  state_t state;
  logic [15:0] cnt;
  logic [31:0] tx;
  logic [31:0] rx;
  logic wr;
  logic unused;
  assign unused = ^{wb_dat_i, wb_adr_i[31:24], wb_adr_i[1:0]};
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= WAKE;
      o_spi_cs_n <= 1'b1;
      o_spi_clk <= 1'b0;
      o_spi_mosi <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      cnt <= '0;
      tx <= '0;
      rx <= '0;
      wr <= 1'b0;
    end else begin
      case (state)
        WAKE, XFER: begin
          if (state == WAKE && o_spi_cs_n) begin
            o_spi_cs_n <= 1'b0;
            tx <= 32'hAB00_0000;
            o_spi_mosi <= 1'b1;
            cnt <= '0;
          end else begin
            o_spi_clk <= ~o_spi_clk;
            // falling SCK edge: sample MISO, present next MOSI bit
            if (o_spi_clk) begin
              tx <= {tx[30:0], 1'b0};
              o_spi_mosi <= tx[30];
              rx <= {rx[30:0], i_spi_miso};
              cnt <= cnt + 16'd1;
            end
            if (o_spi_clk && state == WAKE && cnt == 16'd7) begin
              o_spi_cs_n <= 1'b1;
              cnt <= '0;
              state <= WAKE_WAIT;
            end
            if (o_spi_clk && state == XFER && cnt == 16'd63) state <= ACK;
          end
        end
        WAKE_WAIT: begin
          cnt <= cnt + 16'd1;
          if (cnt == 16'(WAKE_DELAY - 1)) state <= IDLE;
        end
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            wr <= wb_we_i;
            state <= wb_we_i ? ACK : XFER;
            if (!wb_we_i) begin
              o_spi_cs_n <= 1'b0;
              o_spi_mosi <= 1'b0;
              tx <= {8'h03, wb_adr_i[23:2], 2'b00};
              cnt <= '0;
            end
          end
        end
        ACK: begin
          wb_ack_o <= 1'b1;
          o_spi_cs_n <= 1'b1;
          if (!wr) wb_dat_o <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
          state <= GAP;
        end
        GAP: begin
          wb_ack_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= WAKE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_ctrl.sv
// tb_spi_flash_ctrl: directed bench with a behavioural SPI flash model
module tb_spi_flash_ctrl;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        o_spi_cs_n;
  logic        o_spi_clk;
  logic        o_spi_mosi;
  logic        i_spi_miso = 1'b0;

  spi_flash_ctrl dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .o_spi_cs_n(o_spi_cs_n), .o_spi_clk(o_spi_clk),
    .o_spi_mosi(o_spi_mosi), .i_spi_miso(i_spi_miso)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  logic [7:0]  mem [0:1023];
  logic [31:0] rsh = '0;
  logic [7:0]  m_cmd = '0;
  logic [23:0] m_addr = '0;
  int rbits = 0, falls = 0, fb = 0, cs_falls = 0, ack_cnt = 0;
  int n_chk = 0, n_fail = 0;

  // flash model: sample MOSI on SCK rise, shift data out on SCK fall after the 32-bit header
  always @(negedge o_spi_cs_n) begin
    rbits = 0;
    falls = 0;
    cs_falls++;
  end
  always @(posedge o_spi_clk) if (!o_spi_cs_n) begin
    rsh = {rsh[30:0], o_spi_mosi};
    rbits++;
    if (rbits == 8) m_cmd = rsh[7:0];
    if (rbits == 32) m_addr = rsh[23:0];
  end
  always @(negedge o_spi_clk) if (!o_spi_cs_n) begin
    falls++;
    if (falls >= 32 && falls < 64) begin
      fb = falls - 32;
      i_spi_miso = mem[(int'(m_addr) + fb / 8) % 1024][7 - (fb % 8)];
    end
  end
  always @(posedge wb_clk_i) if (wb_ack_o) ack_cnt++;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {mem[(a + 3) % 1024], mem[(a + 2) % 1024], mem[(a + 1) % 1024], mem[a % 1024]};
  endfunction

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wake;
    int k, lo;
    k = 0;
    while (o_spi_cs_n && k < 50) begin
      tick;
      k++;
    end
    lo = 0;
    while (!o_spi_cs_n && lo < 100) begin
      tick;
      lo++;
    end
    chk("wake_cs_low_cycles", lo, 16);
    chk("wake_cmd", m_cmd, 8'hAB);
  endtask

  task automatic read_word(input logic [31:0] a, output int lat, output logic [31:0] d);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i = 1'b0;
    wb_adr_i = a;
    lat = -1;
    d = 'x;
    for (int k = 0; k < 1000; k++) begin
      tick;
      if (wb_ack_o) begin
        lat = k;
        d = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
  endtask

  initial begin
    int lat, cf, a0, hi, nw, last;
    logic [31:0] d;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i ^ (i >> 3));
    tick;
    tick;
    chk("rst_cs_n", o_spi_cs_n, 1);
    chk("rst_sck", o_spi_clk, 0);
    chk("rst_mosi", o_spi_mosi, 0);
    chk("rst_ack", wb_ack_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    wb_rst_i = 1'b0;
    check_wake;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (o_spi_cs_n) hi++;
    end
    chk("wake_wait_cs_high", hi, 30);
    chk("no_ack_after_wake", ack_cnt, 0);

    cf = cs_falls;
    read_word(32'h0, lat, d);
    chk("read0_latency", lat, 129);
    chk("read0_data", d, 32'h0302_0100);
    chk("read0_cmd", m_cmd, 8'h03);
    chk("read0_addr", m_addr, 24'h0);
    tick;
    chk("read0_ack_single", wb_ack_o, 0);
    chk("read0_one_xfer", cs_falls, cf + 1);

    tick;
    cf = cs_falls;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = 32'h0;
    nw = 0;
    last = -1;
    for (int k = 0; k < 45000 && nw < 256; k++) begin
      tick;
      if (wb_ack_o) begin
        chk("burst_word", wb_dat_o, exp_word(wb_adr_i));
        if (nw > 0) chk("burst_spacing", k - last, 131);
        last = k;
        nw++;
        wb_adr_i = wb_adr_i + 32'd4;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    chk("burst_count", nw, 256);
    chk("burst_under_50k", last < 50000, 1);
    chk("burst_xfers", cs_falls, cf + 256);

    tick;
    tick;
    cf = cs_falls;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i = 1'b1;
    wb_adr_i = 32'h10;
    tick;
    chk("write_e0_ack", wb_ack_o, 0);
    tick;
    chk("write_e1_ack", wb_ack_o, 1);
    chk("write_dat_kept", wb_dat_o, exp_word(32'h3FC));
    chk("write_cs_high", o_spi_cs_n, 1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i = 1'b0;
    tick;
    chk("write_e2_ack", wb_ack_o, 0);
    chk("write_no_spi", cs_falls, cf);

    tick;
    a0 = ack_cnt;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_adr_i = 32'h20;
    for (int i = 0; i < 60; i++) tick;
    chk("midread_cs_low", o_spi_cs_n, 0);
    wb_rst_i = 1'b1;
    tick;
    chk("midrst_cs_n", o_spi_cs_n, 1);
    chk("midrst_sck", o_spi_clk, 0);
    chk("midrst_ack", wb_ack_o, 0);
    wb_rst_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    check_wake;
    chk("midrst_no_ack", ack_cnt, a0);
    read_word(32'h20, lat, d);
    chk("after_rst_data", d, 32'h2726_2524);

    tick;
    wb_rst_i = 1'b1;
    tick;
    wb_rst_i = 1'b0;
    read_word(32'h100, lat, d);
    chk("held_during_wake", lat >= 161, 1);
    chk("held_read_data", d, 32'h2322_2120);
    chk("held_read_addr", m_addr, 24'h000100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
